// File: rtl/play_audio_buffer.sv
// play_audio_buffer
//   Stereo sample elastic buffer between the PlayCore/MixCore producer and the
//   AudioBus play port. Samples are held in a first-word-fall-through circular
//   FIFO. Output is withheld (PRIME) until PRIME_LEVEL samples are buffered or
//   drain is asserted with data present, then streamed (STREAM) until an
//   underrun sends the buffer back to PRIME.
//
// Parameters
//   DEPTH        FIFO entries, power of two, >= 4
//   PRIME_LEVEL  occupancy required before output starts, 1..DEPTH
//
// Ports
//   i_clk         clock
//   i_rst         asynchronous active-low reset
//   in_valid      upstream sample valid
//   in_data       sample, [31:16] left, [15:0] right
//   in_ready      buffer can accept (registered, level < DEPTH)
//   out_valid     sample offered to the AudioBus play port
//   out_data      offered sample (entry at read pointer)
//   out_ready     AudioBus accepts
//   flush         synchronous clear, highest priority
//   drain         release buffered samples below PRIME_LEVEL
//   level         current occupancy
//   underrun_cnt  saturating underrun event count (PLAYBUF_STATS_EN only)
//
// Build option
//   PLAYBUF_STATS_EN  adds the underrun_cnt port and its counter.

module play_audio_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PRIME_LEVEL = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic                     drain,
  output logic [$clog2(DEPTH):0]   level
`ifdef PLAYBUF_STATS_EN
  ,
  output logic [15:0]              underrun_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  typedef enum logic [0:0] {
    PRIME  = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q, ready_d;
  logic            push, pop, underrun;

  // in_ready is a flop rather than a decode of level_q so that it reads 0
  // while reset is held and 1 from the first edge after release.
  assign in_ready  = ready_q;
  assign level     = level_q;
  assign out_valid = (state_q == STREAM) && (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];

  assign push     = in_valid && ready_q;
  assign pop      = out_valid && out_ready;
  assign underrun = (state_q == STREAM) && (level_q == '0) && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);

    case (state_q)
      PRIME:   if ((level_q >= PRIME_LVL) || (drain && (level_q != '0))) state_d = STREAM;
      STREAM:  if (underrun) state_d = PRIME;
      default: state_d = PRIME;
    endcase

    // Flush overrides everything computed above.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      state_d  = PRIME;
    end

    ready_d = (level_d != FULL_LVL);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= PRIME;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      ready_q  <= ready_d;
    end
  end

  // Sample storage needs no reset; contents are only visible via level.
  always_ff @(posedge i_clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef PLAYBUF_STATS_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ucnt_q <= '0;
    end else if (underrun && !flush && (ucnt_q != '1)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_play_audio_buffer.sv
// tb_play_audio_buffer
//   Scoreboard bench for play_audio_buffer. The driver queues every accepted
//   sample; a negedge monitor compares the DUT against a queue-based model of
//   buffer occupancy and PRIME/STREAM behaviour and pops on each delivery.

module tb_play_audio_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned PL    = 8;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        in_valid, in_ready, out_valid, out_ready, flush, drain;
  logic [31:0] in_data, out_data;
  logic [4:0]  level;
`ifdef PLAYBUF_STATS_EN
  logic [15:0] underrun_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] exp_q [$];
  bit          m_prime = 1'b1;
  int unsigned exp_uc  = 0;

  always #5 clk = ~clk;

  play_audio_buffer #(
    .DEPTH       (DEPTH),
    .PRIME_LEVEL (PL)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .drain     (drain),
    .level     (level)
`ifdef PLAYBUF_STATS_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive after the edge, record acceptance just after negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                      input logic fl, input logic dr);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    drain     = dr;
    @(negedge clk);
    #1;
    if (i_rst && v && in_ready && !fl) exp_q.push_back(d);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor / reference model.
  initial begin : monitor
    int unsigned sz;
    bit          ev;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_level", {27'b0, level}, 32'd0);
        exp_q.delete();
        m_prime = 1'b1;
        exp_uc  = 0;
      end else begin
        sz = exp_q.size();
        ev = !m_prime && (sz != 0);
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        chk("level", {27'b0, level}, sz);
        chk("in_ready", {31'b0, in_ready}, {31'b0, sz < DEPTH});
        if (ev) chk("out_data", out_data, exp_q[0]);
`ifdef PLAYBUF_STATS_EN
        chk("underrun_cnt", {16'b0, underrun_cnt}, exp_uc);
`endif
        if (flush) begin
          exp_q.delete();
          m_prime = 1'b1;
        end else begin
          if (ev && out_ready) void'(exp_q.pop_front());
          if (m_prime) begin
            if (sz >= PL || (drain && sz != 0)) m_prime = 1'b0;
          end else if (sz == 0 && out_ready) begin
            m_prime = 1'b1;
            if (exp_uc < 32'hFFFF) exp_uc++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    i_rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; drain = 1'b0;
    repeat (3) @(negedge clk);
    #3 i_rst = 1'b1;

    // Priming: 7 samples keep output off, the 8th starts streaming.
    for (int unsigned i = 1; i <= 7; i++) step(1'b1, 32'h00010001 * i, 1'b1, 1'b0, 1'b0);
    chk("prime7_out_valid", {31'b0, out_valid}, 32'd0);
    step(1'b1, 32'h00080008, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("prime8_level", {27'b0, level}, 32'd8);
    idle(1);
    chk("prime_first_valid", {31'b0, out_valid}, 32'd1);
    chk("prime_first_data", out_data, 32'h00010001);

    // Underrun: pop all 8, then one empty cycle with out_ready high.
    for (int unsigned i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("underrun_level", {27'b0, level}, 32'd0);
`ifdef PLAYBUF_STATS_EN
    chk("underrun_cnt_one", {16'b0, underrun_cnt}, 32'd1);
`endif
    for (int unsigned i = 0; i < 7; i++) step(1'b1, 32'h00A00000 + i, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("reprime_out_valid", {31'b0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Full.
    for (int unsigned i = 0; i < 16; i++) step(1'b1, 32'h00001000 + i, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("full_level", {27'b0, level}, 32'd16);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    step(1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("full_17th_level", {27'b0, level}, 32'd16);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("full_pop_in_ready", {31'b0, in_ready}, 32'd1);
    chk("full_pop_level", {27'b0, level}, 32'd15);
    for (int unsigned i = 0; i < 17; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with a concurrent push.
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 32'h00002000 + i, 1'b0, 1'b0, 1'b0);
    chk("preflush_level", {27'b0, level}, 32'd4);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("flush_level", {27'b0, level}, 32'd0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);

    // Drain below the prime level.
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'h00003000 + i, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle(1);
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_level", {27'b0, level}, 32'd0);

    // Asynchronous reset while streaming.
    for (int unsigned i = 0; i < 10; i++) step(1'b1, 32'h00004000 + i, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("prerst_out_valid", {31'b0, out_valid}, 32'd1);
    chk("prerst_level", {27'b0, level}, 32'd10);
    @(posedge clk);
    #3;
    in_valid = 1'b0; out_ready = 1'b0; drain = 1'b0; flush = 1'b0;
    i_rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_level", {27'b0, level}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    #3 i_rst = 1'b1;

    // Randomized traffic.
    for (int unsigned n = 0; n < 2000; n++) begin
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 55,
           $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 10);
    end
    for (int unsigned i = 0; i < 40; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("final_level", {27'b0, level}, 32'd0);
    chk("final_scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
